ram_arbiter: RTL

- Shares the 4096x4 data RAM between the nibble CPU and a host port used for debug, program-variable preload and readback.
- The CPU accesses RAM during its execute phase; the host issues incrementing bursts through a req/gnt handshake.
- Sits between the CPU's csRAM/weRAM/address_RAM/data_bus and the RAM. All buses are unidirectional; the tristate data_bus adapter lives outside this block.
- Asserts cpu_stall while the CPU is locked out; the top level gates phase/PC/accumulator enables with it.

---
 rtl/ram_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Arbitrates the shared data RAM between the nibble CPU and a host burst port.
// The CPU owns the RAM by default; host bursts are granted when the CPU is idle or has starved the host too long.
module ram_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 4,
  parameter int MAX_BURST  = 8,
  parameter int STARVE_LIM = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [3:0]        host_len,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_beat,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_done,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int SC_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {IDLE, BURST, CPU_SLOT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [4:0]        beats;
  logic [SC_W-1:0]   starve_cnt;

  logic              starved;
  logic              grant;
  logic [4:0]        req_len;
  logic [4:0]        len_p1;

  always_comb begin
    starved = (starve_cnt == SC_W'(STARVE_LIM));
    grant   = reset && (state == IDLE) && host_req && (!cpu_cs || starved);
    len_p1  = {1'b0, host_len} + 5'd1;
    req_len = (len_p1 > 5'(MAX_BURST)) ? 5'(MAX_BURST) : len_p1;
  end

  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    cpu_rdata = '0;
    cpu_stall = 1'b0;
    if (state == BURST) begin
      ram_cs    = 1'b1;
      ram_we    = we_q;
      ram_addr  = addr_q;
      ram_wdata = host_wdata;
      cpu_stall = cpu_cs;
    end else if (grant && cpu_cs) begin
      // forced grant: the CPU loses this cycle and the RAM is left unselected
      cpu_stall = 1'b1;
    end else begin
      ram_cs    = cpu_cs;
      ram_we    = cpu_we;
      cpu_rdata = ram_rdata;
    end
    if (!reset) begin
      ram_cs = 1'b0;
      ram_we = 1'b0;
    end
  end

  assign host_gnt  = grant;
  assign host_beat = (state == BURST);
  assign host_done = (state == CPU_SLOT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      beats       <= '0;
      starve_cnt  <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= (state == BURST) && !we_q;
      if ((state == BURST) && !we_q)
        host_rdata <= ram_rdata;
      case (state)
        IDLE: begin
          if (grant) begin
            addr_q     <= host_addr;
            we_q       <= host_we;
            beats      <= req_len;
            starve_cnt <= '0;
            state      <= BURST;
          end else if (host_req && cpu_cs) begin
            starve_cnt <= starve_cnt + SC_W'(1);
          end else begin
            starve_cnt <= '0;
          end
        end
        BURST: begin
          addr_q <= addr_q + ADDR_W'(1);
          beats  <= beats - 5'd1;
          if (beats == 5'd1)
            state <= CPU_SLOT;
        end
        CPU_SLOT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule
